prog_mem_pp_ctrl: RTL



---
 rtl/prog_mem_pkg.sv | 60 ++++++
 rtl/prog_mem_op_timer.sv | 28 ++
 rtl/prog_mem_pp_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program-flash parallel-programming controller.
package prog_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_LOAD,
        ST_PG_ERASE,
        ST_PG_PROG,
        ST_CHIP_ER,
        ST_RD
    } state_t;

    typedef enum logic [3:0] {
        CMD_NONE,
        CMD_CHIP,
        CMD_WRITE,
        CMD_READ,
        CMD_NOP,
        CMD_ADR_LO,
        CMD_ADR_HI,
        CMD_DAT_LO,
        CMD_DAT_HI,
        CMD_BAD
    } cmd_t;

    localparam logic [7:0] OP_CHIP  = 8'h80;
    localparam logic [7:0] OP_WRITE = 8'h10;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_NOP   = 8'h00;

    localparam logic [1:0] XA_ADR = 2'b00;
    localparam logic [1:0] XA_DAT = 2'b01;
    localparam logic [1:0] XA_CMD = 2'b10;

    localparam int unsigned BK_RWW  = 0;
    localparam int unsigned BK_NRWW = 1;

    // Map one XA/BS1/DATA strobe onto a command; anything unrecognised is CMD_BAD
    function automatic cmd_t decode_cmd(input logic [1:0] xa, input logic bs1,
                                        input logic [7:0] data);
        cmd_t c;
        c = CMD_BAD;
        case (xa)
            XA_ADR: c = bs1 ? CMD_ADR_HI : CMD_ADR_LO;
            XA_DAT: c = bs1 ? CMD_DAT_HI : CMD_DAT_LO;
            XA_CMD: begin
                case (data)
                    OP_CHIP:  c = CMD_CHIP;
                    OP_WRITE: c = CMD_WRITE;
                    OP_READ:  c = CMD_READ;
                    OP_NOP:   c = CMD_NOP;
                    default:  c = CMD_BAD;
                endcase
            end
            default: c = CMD_BAD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/prog_mem_op_timer.sv
// Down-counter for erase/program intervals: loaded on start, holds at zero.
module prog_mem_op_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Load on start, otherwise count down and stop at zero
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (start) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    // Final cycle of the interval; the owner leaves its busy state on this edge
    always_comb done = (count == CNT_W'(1));

endmodule

// File: rtl/prog_mem_pp_ctrl.sv
// Parallel-programming controller for the program flash: command decode,
// page-buffer loading, timed erase/program, and RWW/NRWW fetch arbitration.
module prog_mem_pp_ctrl
    import prog_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 14,
    parameter int unsigned       PAGE_W    = 6,
    parameter int unsigned       SECT_W    = 3,
    parameter logic [SECT_W-1:0] NRWW_TAG  = 3'b111,
    parameter int unsigned       ERASE_CYC = 32000,
    parameter int unsigned       PROG_CYC  = 32000,
    parameter int unsigned       CHIP_CYC  = 64000
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cmd_stb,
    input  logic [1:0]        xa,
    input  logic              bs1,
    input  logic              wr_n,
    input  logic              oe_n,
    input  logic [7:0]        data_in,
    input  logic              pc_rd,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] prog_adr,
    output logic [PAGE_W-1:0] buf_idx,
    output logic [15:0]       buf_data,
    output logic              en_buf,
    output logic              en_adr_lat,
    output logic              erase,
    output logic              prog,
    output logic              en_chip_erase,
    output logic              db_rd,
    output logic              data_rd,
    output logic              rd_highbyte,
    output logic              mem_rd,
    output logic [1:0]        bk_sel,
    output logic              cpu_stall,
    output logic              rdy,
    output logic              cmd_err
);

    localparam int unsigned MAX_EP  = (ERASE_CYC > PROG_CYC) ? ERASE_CYC : PROG_CYC;
    localparam int unsigned MAX_CYC = (CHIP_CYC > MAX_EP) ? CHIP_CYC : MAX_EP;
    localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

    state_t           state_q, state_d;
    cmd_t             cmd;
    logic             busy, ld_ok, wr_fall, adr_nrww, pc_nrww;
    logic             tmr_start, tmr_done;
    logic [TMR_W-1:0] tmr_load;
    logic             en_buf_d, en_adr_lat_d, cmd_err_d;
    logic             wr_n_q, data_rd_q, rd_pend, drd_req;
    logic             unused_pc_lo;

    assign unused_pc_lo = ^pc[ADDR_W-SECT_W-1:0];

    prog_mem_op_timer #(.CNT_W(TMR_W)) u_timer (
        .clk      (clk),
        .nrst     (nrst),
        .start    (tmr_start),
        .load_val (tmr_load),
        .done     (tmr_done)
    );

    // Decode, next-state selection and state-derived outputs
    always_comb begin
        cmd      = cmd_stb ? decode_cmd(xa, bs1, data_in) : CMD_NONE;
        busy     = (state_q == ST_PG_ERASE) || (state_q == ST_PG_PROG) ||
                   (state_q == ST_CHIP_ER);
        adr_nrww = (prog_adr[ADDR_W-1 -: SECT_W] == NRWW_TAG);
        pc_nrww  = (pc[ADDR_W-1 -: SECT_W] == NRWW_TAG);
        wr_fall  = wr_n_q & ~wr_n;
        ld_ok    = ~busy & (cmd inside {CMD_ADR_LO, CMD_ADR_HI, CMD_DAT_LO, CMD_DAT_HI});

        state_d      = state_q;
        tmr_start    = 1'b0;
        tmr_load     = '0;
        en_buf_d     = 1'b0;
        en_adr_lat_d = 1'b0;
        cmd_err_d    = busy ? cmd_stb : (cmd == CMD_BAD);

        // Commands that do not fit the current mode are rejected; NOP is the exit
        case (state_q)
            ST_IDLE: begin
                case (cmd)
                    CMD_WRITE: state_d = ST_WR_LOAD;
                    CMD_READ:  state_d = ST_RD;
                    CMD_CHIP: begin
                        if (pc_rd) begin
                            cmd_err_d = 1'b1;
                        end else begin
                            state_d   = ST_CHIP_ER;
                            tmr_start = 1'b1;
                            tmr_load  = TMR_W'(CHIP_CYC);
                        end
                    end
                    default: ;
                endcase
            end
            ST_WR_LOAD: begin
                en_adr_lat_d = (cmd == CMD_ADR_LO) || (cmd == CMD_ADR_HI);
                en_buf_d     = (cmd == CMD_DAT_HI);
                if (cmd == CMD_NOP) begin
                    state_d = ST_IDLE;
                end else if ((cmd == CMD_READ) || (cmd == CMD_CHIP)) begin
                    cmd_err_d = 1'b1;
                end else if (wr_fall) begin
                    state_d   = ST_PG_ERASE;
                    tmr_start = 1'b1;
                    tmr_load  = TMR_W'(ERASE_CYC);
                end
            end
            ST_PG_ERASE: begin
                if (tmr_done) begin
                    state_d   = ST_PG_PROG;
                    tmr_start = 1'b1;
                    tmr_load  = TMR_W'(PROG_CYC);
                end
            end
            ST_PG_PROG: begin
                if (tmr_done) state_d = ST_WR_LOAD;
            end
            ST_CHIP_ER: begin
                if (tmr_done) state_d = ST_IDLE;
            end
            ST_RD: begin
                if (cmd == CMD_NOP) begin
                    state_d = ST_IDLE;
                end else if ((cmd == CMD_WRITE) || (cmd == CMD_CHIP)) begin
                    cmd_err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        erase         = (state_q == ST_PG_ERASE);
        prog          = (state_q == ST_PG_PROG);
        en_chip_erase = (state_q == ST_CHIP_ER);
        db_rd         = (state_q == ST_RD);
        data_rd       = db_rd & ~oe_n;
        rd_highbyte   = data_rd & bs1;
        rdy           = ~busy;
        buf_idx       = prog_adr[PAGE_W-1:0];

        bk_sel = '0;
        if (erase || prog) begin
            bk_sel[BK_NRWW] = adr_nrww;
            bk_sel[BK_RWW]  = ~adr_nrww;
        end else if (en_chip_erase) begin
            bk_sel = '1;
        end
        cpu_stall = pc_rd & (pc_nrww ? bk_sel[BK_NRWW] : bk_sel[BK_RWW]);
        drd_req   = (data_rd & ~data_rd_q) | rd_pend;
    end

    // State register; reset aborts any erase/program in flight
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Address/data latches and one-cycle strobes; page index wraps inside the page
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prog_adr   <= '0;
            buf_data   <= '0;
            en_buf     <= 1'b0;
            en_adr_lat <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            en_buf     <= en_buf_d;
            en_adr_lat <= en_adr_lat_d;
            cmd_err    <= cmd_err_d;
            if (ld_ok && (cmd == CMD_ADR_LO)) begin
                prog_adr[7:0] <= data_in;
            end else if (ld_ok && (cmd == CMD_ADR_HI)) begin
                prog_adr[ADDR_W-1:8] <= data_in[ADDR_W-9:0];
            end else if (en_buf) begin
                prog_adr[PAGE_W-1:0] <= prog_adr[PAGE_W-1:0] + PAGE_W'(1);
            end
            if (ld_ok && (cmd == CMD_DAT_LO)) buf_data[7:0]  <= data_in;
            if (ld_ok && (cmd == CMD_DAT_HI)) buf_data[15:8] <= data_in;
        end
    end

    // Flash read strobe: a fetch wins, a colliding data read is held one cycle
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_n_q    <= 1'b1;
            data_rd_q <= 1'b0;
            rd_pend   <= 1'b0;
            mem_rd    <= 1'b0;
        end else begin
            wr_n_q    <= wr_n;
            data_rd_q <= data_rd;
            mem_rd    <= (pc_rd & ~cpu_stall) | drd_req;
            rd_pend   <= (pc_rd & ~cpu_stall) & drd_req;
        end
    end

endmodule
